// File: rtl/alu_exec_if.sv
// ---------------------------------------------------------------------------
// alu_exec_if -- instruction / status / GPR access bundle for alu_exec_unit.
//
// Signals:
//   instr[31:0]       instruction word (held by master while instr_valid)
//   instr_valid       master offers an instruction
//   instr_ready       slave can accept; transfer on an edge with both high
//   done              one-cycle writeback pulse
//   illegal           qualifies done: opcode was rejected
//   flags[3:0]        {V,C,S,Z}
//   gpr_we/gpr_waddr/gpr_wdata   GPR preload port (idle only)
//   dbg_addr/dbg_data            combinational GPR read port
//
// master = instruction source / testbench, slave = alu_exec_unit.
// ---------------------------------------------------------------------------
interface alu_exec_if #(
    parameter int DATA_W = 16
);
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              done;
    logic              illegal;
    logic [3:0]        flags;
    logic              gpr_we;
    logic [4:0]        gpr_waddr;
    logic [DATA_W-1:0] gpr_wdata;
    logic [4:0]        dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output instr, instr_valid, gpr_we, gpr_waddr, gpr_wdata, dbg_addr,
        input  instr_ready, done, illegal, flags, dbg_data
    );

    modport slave (
        input  instr, instr_valid, gpr_we, gpr_waddr, gpr_wdata, dbg_addr,
        output instr_ready, done, illegal, flags, dbg_data
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit -- multi-cycle ALU with a GPR file, an SGPR (high half of the
// last multiply) and a registered {V,C,S,Z} flag register.
//
// Ports:
//   clk        rising-edge clock
//   sys_rst    asynchronous active-high reset
//   bus        alu_exec_if.slave (instruction handshake, done/illegal/flags,
//              GPR preload and debug read)
//
// Instruction word: op[31:27] rdst[26:22] rsrc1[21:17] imm_mode[16]
//                   rsrc2[15:11] isrc[15:0]
// Flow: IDLE -accept-> EXEC -> (MUL x DATA_W) -> WB -> IDLE. The WB edge
// performs the register/flag write and raises done for the following cycle.
//
// Build option: define ALU_MUL_EN to include the iterative shift-add
// multiplier (opcode 4). Without it opcode 4 is rejected as illegal and the
// SGPR stays zero.
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 32
) (
    input  logic      clk,
    input  logic      sys_rst,
    alu_exec_if.slave bus
);
    localparam int AW = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_OR      = 5'd5;
    localparam logic [4:0] OP_AND     = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_XNOR    = 5'd8;
    localparam logic [4:0] OP_NAND    = 5'd9;
    localparam logic [4:0] OP_NOR     = 5'd10;
    localparam logic [4:0] OP_NOT     = 5'd11;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
`endif

    state_t            state_q;
    logic [DATA_W-1:0] gpr_q [REG_CNT];
    logic [DATA_W-1:0] sgpr_q;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic [4:0]        op_q, rdst_q;
    logic              c_q, v_q;
    logic              done_q, illegal_q;
    logic [3:0]        flags_q;

`ifdef ALU_MUL_EN
    logic [2*DATA_W-1:0] acc_q, mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [6:0]          cnt_q;
`endif

    // Out-of-range addresses read as zero.
    function automatic logic [DATA_W-1:0] rd_gpr(input logic [4:0] addr);
        rd_gpr = '0;
        if (int'(addr) < REG_CNT) rd_gpr = gpr_q[addr[AW-1:0]];
    endfunction

    // Instruction field decode (used only at acceptance).
    logic [4:0]        in_op, in_rdst, in_rs1, in_rs2;
    logic              in_imm;
    logic [15:0]       in_isrc;
    logic [DATA_W-1:0] opa_d, opb_d;

    assign in_op   = bus.instr[31:27];
    assign in_rdst = bus.instr[26:22];
    assign in_rs1  = bus.instr[21:17];
    assign in_imm  = bus.instr[16];
    assign in_rs2  = bus.instr[15:11];
    assign in_isrc = bus.instr[15:0];
    assign opa_d   = rd_gpr(in_rs1);
    assign opb_d   = in_imm ? DATA_W'(in_isrc) : rd_gpr(in_rs2);

    // Single-cycle ALU on the latched operands, evaluated in EXEC.
    logic [DATA_W:0]   sum_d, diff_d;
    logic [DATA_W-1:0] alu_res_d;
    logic              alu_c_d, alu_v_d;

    always_comb begin
        sum_d     = {1'b0, a_q} + {1'b0, b_q};
        diff_d    = {1'b0, a_q} + {1'b0, ~b_q} + (DATA_W+1)'(1);
        alu_res_d = '0;
        alu_c_d   = 1'b0;
        alu_v_d   = 1'b0;
        case (op_q)
            OP_MOVSGPR: alu_res_d = sgpr_q;
            OP_MOV:     alu_res_d = b_q;
            OP_ADD: begin
                alu_res_d = sum_d[DATA_W-1:0];
                alu_c_d   = sum_d[DATA_W];
                alu_v_d   = (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                            (sum_d[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res_d = diff_d[DATA_W-1:0];
                alu_c_d   = diff_d[DATA_W];
                alu_v_d   = (a_q[DATA_W-1] != b_q[DATA_W-1]) &&
                            (diff_d[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_OR:   alu_res_d = a_q | b_q;
            OP_AND:  alu_res_d = a_q & b_q;
            OP_XOR:  alu_res_d = a_q ^ b_q;
            OP_XNOR: alu_res_d = ~(a_q ^ b_q);
            OP_NAND: alu_res_d = ~(a_q & b_q);
            OP_NOR:  alu_res_d = ~(a_q | b_q);
            OP_NOT:  alu_res_d = ~a_q;
            default: alu_res_d = '0;
        endcase
    end

    logic              illegal_d;
    logic [DATA_W-1:0] wb_val_d;
    logic [3:0]        wb_flags_d;

`ifdef ALU_MUL_EN
    assign illegal_d = (op_q > OP_NOT);
    assign wb_val_d  = (op_q == OP_MUL) ? acc_q[DATA_W-1:0] : res_q;
`else
    assign illegal_d = (op_q > OP_NOT) || (op_q == OP_MUL);
    assign wb_val_d  = res_q;
`endif
    // C/V were captured in EXEC and are zero for every non-ADD/SUB op.
    assign wb_flags_d = {v_q, c_q, wb_val_d[DATA_W-1], (wb_val_d == '0)};

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            flags_q   <= '0;
            sgpr_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            op_q      <= '0;
            rdst_q    <= '0;
            c_q       <= 1'b0;
            v_q       <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) gpr_q[i] <= '0;
`ifdef ALU_MUL_EN
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Preload has priority and blocks acceptance this cycle.
                    if (bus.gpr_we) begin
                        if (int'(bus.gpr_waddr) < REG_CNT)
                            gpr_q[bus.gpr_waddr[AW-1:0]] <= bus.gpr_wdata;
                    end else if (bus.instr_valid) begin
                        op_q    <= in_op;
                        rdst_q  <= in_rdst;
                        a_q     <= opa_d;
                        b_q     <= opb_d;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q   <= alu_res_d;
                    c_q     <= alu_c_d;
                    v_q     <= alu_v_d;
                    state_q <= S_WB;
`ifdef ALU_MUL_EN
                    if (op_q == OP_MUL) begin
                        acc_q    <= '0;
                        mcand_q  <= {{DATA_W{1'b0}}, a_q};
                        mplier_q <= b_q;
                        cnt_q    <= '0;
                        state_q  <= S_MUL;
                    end
`endif
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    // One multiplier bit per cycle, LSB first.
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 7'd1;
                    if (cnt_q == 7'(DATA_W - 1)) state_q <= S_WB;
                end
`endif
                S_WB: begin
                    done_q    <= 1'b1;
                    illegal_q <= illegal_d;
                    if (!illegal_d) begin
                        if (int'(rdst_q) < REG_CNT) gpr_q[rdst_q[AW-1:0]] <= wb_val_d;
                        flags_q <= wb_flags_d;
`ifdef ALU_MUL_EN
                        if (op_q == OP_MUL) sgpr_q <= acc_q[2*DATA_W-1:DATA_W];
`endif
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (state_q == S_IDLE) && !bus.gpr_we && !sys_rst;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
    assign bus.flags       = flags_q;
    assign bus.dbg_data    = rd_gpr(bus.dbg_addr);
endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 clk = ~clk;

    alu_exec_if #(.DATA_W(16)) bus ();

    alu_exec_unit #(.DATA_W(16), .REG_CNT(32)) dut (
        .clk(clk), .sys_rst(sys_rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    int unsigned gpr_m [32];
    int unsigned sgpr_m;
    logic [3:0]  flags_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx16(input int unsigned x);
        return (x >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) gpr_m[i] = 0;
        sgpr_m  = 0;
        flags_m = 4'b0;
    endtask

    // Architectural effect of one instruction, from the opcode table.
    task automatic model_exec(input logic [31:0] ins, output int lat, output bit ill);
        int unsigned op, rd, rs1, a, b, res;
        longint unsigned p;
        int s;
        bit c, v;
        op  = ins[31:27];
        rd  = ins[26:22];
        rs1 = ins[21:17];
        a   = gpr_m[rs1];
        b   = ins[16] ? int'(ins[15:0]) : gpr_m[ins[15:11]];
        ill = (op >= 12) || (op == 4 && !MUL_EN);
        lat = (op == 4 && MUL_EN) ? 18 : 2;
        c = 0; v = 0; res = 0; p = 0;
        case (op)
            0:  res = sgpr_m;
            1:  res = b;
            2: begin
                res = (a + b) % 65536;
                c   = (a + b) >= 65536;
                s   = sx16(a) + sx16(b);
                v   = (s > 32767) || (s < -32768);
            end
            3: begin
                res = (a + 65536 - b) % 65536;
                c   = (a >= b);
                s   = sx16(a) - sx16(b);
                v   = (s > 32767) || (s < -32768);
            end
            4: begin
                p   = longint'(a) * longint'(b);
                res = int'(p % 65536);
            end
            5:  res = a | b;
            6:  res = a & b;
            7:  res = a ^ b;
            8:  res = ~(a ^ b) & 65535;
            9:  res = ~(a & b) & 65535;
            10: res = ~(a | b) & 65535;
            11: res = ~a & 65535;
            default: res = 0;
        endcase
        if (!ill) begin
            gpr_m[rd] = res;
            if (op == 4) sgpr_m = int'(p / 65536);
            flags_m = {v, c, (res >= 32768), (res == 0)};
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.gpr_we = 1'b1; bus.gpr_waddr = a; bus.gpr_wdata = d;
        @(posedge clk); #1;
        bus.gpr_we = 1'b0;
        gpr_m[a] = d;
    endtask

    task automatic peek(input logic [4:0] a, output logic [15:0] v);
        bus.dbg_addr = a; #1;
        v = bus.dbg_data;
    endtask

    task automatic run(input logic [31:0] ins, input string tag);
        int lat_exp, n;
        bit ill_exp;
        logic [15:0] v;
        model_exec(ins, lat_exp, ill_exp);
        @(negedge clk);
        bus.instr = ins; bus.instr_valid = 1'b1;
        n = 0;
        while (!bus.instr_ready && n < 20) begin @(negedge clk); n++; end
        check({tag, "_ready"}, bus.instr_ready, 1'b1);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.instr = $urandom;                // later changes must not matter
        check({tag, "_busy"}, bus.instr_ready, 1'b0);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1; n++;
            if (bus.done) break;
        end
        check({tag, "_latency"}, n, lat_exp);
        check({tag, "_illegal"}, bus.illegal, ill_exp);
        check({tag, "_flags"}, bus.flags, flags_m);
        peek(ins[26:22], v);
        check({tag, "_rdst"}, v, gpr_m[ins[26:22]]);
        @(posedge clk); #1;
        check({tag, "_pulse"}, bus.done, 1'b0);
    endtask

    initial begin
        logic [15:0] v;
        logic [4:0]  op, rd, rs1;
        logic [15:0] isrc;
        logic        imm;
        logic [3:0]  fsave;
        int          seen;

        bus.instr = '0; bus.instr_valid = 1'b0; bus.gpr_we = 1'b0;
        bus.gpr_waddr = '0; bus.gpr_wdata = '0; bus.dbg_addr = '0;
        model_reset();

        // Reset state
        #2;
        check("rst_ready", bus.instr_ready, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_illegal", bus.illegal, 1'b0);
        check("rst_flags", bus.flags, 4'b0);
        peek(5'd7, v);
        check("rst_gpr7", v, 16'h0);
        repeat (2) @(negedge clk);
        sys_rst = 1'b0;
        #1 check("rel_ready", bus.instr_ready, 1'b1);

        for (int i = 0; i < 32; i++) preload(5'(i), 16'd2);

        // ADD immediate
        run({5'd2, 5'd0, 5'd2, 1'b1, 16'd4}, "addi");
        peek(5'd0, v);
        check("addi_val", v, 16'd6);
        check("addi_flg", bus.flags, 4'b0000);

        // SUB register, negative result
        preload(5'd5, 16'd3);
        run({5'd3, 5'd0, 5'd4, 1'b0, 5'd5, 11'd0}, "subr");
        peek(5'd0, v);
        check("subr_val", v, 16'hFFFF);
        check("subr_flg", bus.flags, 4'b0010);

        // ANDI -> zero, XORI
        run({5'd6, 5'd1, 5'd7, 1'b1, 16'd56}, "andi");
        peek(5'd1, v);
        check("andi_val", v, 16'd0);
        check("andi_flg", bus.flags, 4'b0001);
        run({5'd7, 5'd1, 5'd7, 1'b1, 16'd56}, "xori");
        peek(5'd1, v);
        check("xori_val", v, 16'd58);
        check("xori_flg", bus.flags, 4'b0000);

        // MUL then MOVSGPR (opcode 4 is illegal in the no-multiplier build)
        preload(5'd1, 16'h1234);
        run({5'd4, 5'd3, 5'd1, 1'b1, 16'h0100}, "mul");
        peek(5'd3, v);
        check("mul_lo", v, MUL_EN ? 16'h3400 : 16'h0002);
        run({5'd0, 5'd6, 5'd0, 1'b0, 16'd0}, "movsgpr");
        peek(5'd6, v);
        check("movsgpr_val", v, MUL_EN ? 16'h0012 : 16'h0000);

        // Illegal opcode 20: nothing changes
        fsave = bus.flags;
        run({5'd20, 5'd6, 5'd1, 1'b1, 16'h7777}, "op20");
        check("op20_flg", bus.flags, fsave);
        peek(5'd6, v);
        check("op20_rd", v, MUL_EN ? 16'h0012 : 16'h0000);

        // Randomised instruction stream
        for (int i = 0; i < 32; i++) preload(5'(i), 16'($urandom));
        for (int i = 0; i < 60; i++) begin
            op = 5'($urandom_range(0, 15));
            if (op > 13) op = 5'($urandom_range(12, 31));
            rd   = 5'($urandom_range(0, 31));
            rs1  = 5'($urandom_range(0, 31));
            imm  = 1'($urandom_range(0, 1));
            isrc = 16'($urandom);
            run({op, rd, rs1, imm, isrc}, $sformatf("rnd%0d_op%0d", i, op));
        end
        for (int i = 0; i < 32; i++) begin
            peek(5'(i), v);
            check($sformatf("final_gpr%0d", i), v, gpr_m[i]);
        end

        // Preload held high in IDLE blocks acceptance
        @(negedge clk);
        bus.gpr_we = 1'b1; bus.gpr_waddr = 5'd9; bus.gpr_wdata = 16'h0ABC;
        bus.instr = {5'd2, 5'd10, 5'd9, 1'b1, 16'd1}; bus.instr_valid = 1'b1;
        #1 check("we_block_ready", bus.instr_ready, 1'b0);
        seen = 0;
        repeat (3) begin @(posedge clk); #1; if (bus.done) seen++; end
        @(negedge clk);
        bus.gpr_we = 1'b0; bus.instr_valid = 1'b0;
        gpr_m[9] = 16'h0ABC;
        repeat (3) begin @(posedge clk); #1; if (bus.done) seen++; end
        check("we_block_nodone", seen, 0);
        peek(5'd9, v);
        check("we_block_gpr9", v, gpr_m[9]);
        peek(5'd10, v);
        check("we_block_gpr10", v, gpr_m[10]);

        // Reset in the middle of an operation
        preload(5'd2, 16'h00FF);
        @(negedge clk);
        bus.instr = {MUL_EN ? 5'd4 : 5'd2, 5'd12, 5'd2, 1'b1, 16'h0033};
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        repeat (MUL_EN ? 5 : 1) @(posedge clk);
        #1 sys_rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_ready", bus.instr_ready, 1'b0);
        check("mid_rst_done", bus.done, 1'b0);
        check("mid_rst_flags", bus.flags, flags_m);
        peek(5'd2, v);
        check("mid_rst_gpr2", v, 16'h0);
        @(negedge clk);
        sys_rst = 1'b0;
        #1 check("mid_rel_ready", bus.instr_ready, 1'b1);
        seen = 0;
        repeat (25) begin @(posedge clk); #1; if (bus.done) seen++; end
        check("mid_rst_nodone", seen, 0);
        peek(5'd12, v);
        check("mid_rst_rd", v, 16'h0);

        // Still functional after reset
        run({5'd3, 5'd4, 5'd4, 1'b1, 16'd1}, "post_rst_sub");
        peek(5'd4, v);
        check("post_rst_val", v, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
